lsu_dmem_ctrl: RTL and testbench

- Parametrised load/store unit with built-in byte-addressable data memory. It is the next-generation replacement for the core's word-only data memory.
- Supports RV32I LB/LH/LW/LBU/LHU/SB/SH/SW with sign/zero extension.
- Detects misaligned and out-of-range accesses.
- Uses a valid/ready request and valid-only response handshake with configurable read latency.
- Optional reset-time memory clear sequence.
- Sits between the core's execute stage (ALU address, rs2 data, funct3) and the writeback mux.

---
 rtl/lsu_pkg.sv | 41 ++++
 rtl/lsu_dmem_ctrl_if.sv | 28 ++
 rtl/dmem_byte_ram.sv | 38 +++
 rtl/lsu_dmem_ctrl.sv | 154 +++++++++++++++
 tb/tb_lsu_dmem_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// lsu_pkg : funct3 encodings, controller states and load-extension helper
// Revision: 1.0
// ============================================================================
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_W = 4;

  typedef enum logic [1:0] {
    CLEAR   = 2'd0,
    IDLE    = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_B:    res = {{24{b[7]}}, b};
      F3_H:    res = {{16{h[15]}}, h};
      F3_BU:   res = {24'h0, b};
      F3_HU:   res = {16'h0, h};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_dmem_ctrl_if.sv
`default_nettype none
// ============================================================================
// lsu_dmem_ctrl_if : request/response bus between execute stage and the LSU
// Revision: 1.0
// ============================================================================
interface lsu_dmem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_byte_ram.sv
`default_nettype none
// ============================================================================
// dmem_byte_ram : word-organised RAM, byte-enable write port, registered read
// Revision: 1.0
// ============================================================================
module dmem_byte_ram
  import lsu_pkg::*;
#(
  parameter  int DEPTH_WORDS = 64,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  wire logic            clk,
  input  wire logic            i_we,
  input  wire logic [BE_W-1:0] i_be,
  input  wire logic [AW-1:0]   i_waddr,
  input  wire logic [31:0]     i_wdata,
  input  wire logic            i_re,
  input  wire logic [AW-1:0]   i_raddr,
  output logic      [31:0]     o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
    // Read register only moves on a load, so it holds the last load word
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// lsu_dmem_ctrl : RV32I load/store unit with byte-addressable data memory
// Revision: 1.0
// ============================================================================
module lsu_dmem_ctrl
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS    = 64,
  parameter int RD_LATENCY     = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input wire logic        clk,
  input wire logic        reset,
  lsu_dmem_ctrl_if.slave  bus
);

  localparam int             AW          = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0]  c_LAST      = AW'(DEPTH_WORDS - 1);
  localparam logic [1:0]     c_LAT_INIT  = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;
  localparam state_e         c_RST_STATE = CLEAR_ON_RESET ? CLEAR : IDLE;

  state_e        r_state;
  logic [AW-1:0] r_clr_cnt;
  logic [1:0]    r_lat;
  logic          r_rsp_valid, r_rsp_err, r_rsp_load;
  logic [2:0]    r_ld_f3, r_rsp_f3;
  logic [1:0]    r_ld_lane, r_rsp_lane;

  logic          w_accept, w_f3_ok, w_misalign, w_range, w_err;
  logic          w_store, w_load, w_clearing;
  logic [AW-1:0] w_word;
  logic [3:0]    w_be;
  logic [31:0]   w_st_data, w_ram_rdata, w_ld_word;

  wire logic [2:0]  w_f3   = bus.req_funct3;
  wire logic [31:0] w_addr = bus.req_addr;

  assign w_accept   = bus.req_valid && bus.req_ready;
  assign w_f3_ok    = (w_f3 == F3_B) || (w_f3 == F3_H) || (w_f3 == F3_W) ||
                      (!bus.req_we && ((w_f3 == F3_BU) || (w_f3 == F3_HU)));
  assign w_misalign = ((w_f3[1:0] == 2'b01) && w_addr[0]) ||
                      ((w_f3[1:0] == 2'b10) && (w_addr[1:0] != 2'b00));
  assign w_range    = |w_addr[31:AW+2];
  assign w_err      = !w_f3_ok || w_misalign || w_range;
  assign w_word     = w_addr[AW+1:2];
  assign w_store    = w_accept && bus.req_we && !w_err;
  assign w_load     = w_accept && !bus.req_we && !w_err;
  assign w_clearing = (r_state == CLEAR) && !reset;

  always_comb begin
    w_be      = 4'b1111;
    w_st_data = bus.req_wdata;
    case (w_f3[1:0])
      2'b00: begin
        w_be      = 4'b0001 << w_addr[1:0];
        w_st_data = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        w_be      = w_addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  dmem_byte_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .i_we    (w_clearing || w_store),
    .i_be    (w_clearing ? 4'b1111 : w_be),
    .i_waddr (w_clearing ? r_clr_cnt : w_word),
    .i_wdata (w_clearing ? 32'h0 : w_st_data),
    .i_re    (w_load),
    .i_raddr (w_word),
    .o_rdata (w_ram_rdata)
  );

  // The RAM register supplies one cycle; the rest of the latency lives here
  generate
    if (RD_LATENCY > 1) begin : g_delay
      logic [31:0] r_dly [RD_LATENCY-1];
      always_ff @(posedge clk) begin
        r_dly[0] <= w_ram_rdata;
        for (int k = 1; k < RD_LATENCY - 1; k++) r_dly[k] <= r_dly[k-1];
      end
      assign w_ld_word = r_dly[RD_LATENCY-2];
    end else begin : g_no_delay
      assign w_ld_word = w_ram_rdata;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= c_RST_STATE;
      r_clr_cnt   <= '0;
      r_lat       <= 2'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_load  <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == c_LAST) r_state <= IDLE;
        end
        IDLE: begin
          if (w_accept) begin
            if (w_err || bus.req_we) begin
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= w_err;
              r_rsp_load  <= 1'b0;
            end else begin
              r_ld_f3   <= w_f3;
              r_ld_lane <= w_addr[1:0];
              if (RD_LATENCY == 1) begin
                r_rsp_valid <= 1'b1;
                r_rsp_load  <= 1'b1;
                r_rsp_f3    <= w_f3;
                r_rsp_lane  <= w_addr[1:0];
              end else begin
                r_lat   <= c_LAT_INIT;
                r_state <= RD_WAIT;
              end
            end
          end
        end
        RD_WAIT: begin
          if (r_lat == 2'd0) begin
            r_rsp_valid <= 1'b1;
            r_rsp_load  <= 1'b1;
            r_rsp_f3    <= r_ld_f3;
            r_rsp_lane  <= r_ld_lane;
            r_state     <= IDLE;
          end else begin
            r_lat <= r_lat - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Extension info is latched with the response so rdata holds until the next one
  assign bus.req_ready = (r_state == IDLE) && !reset;
  assign bus.busy      = reset ? CLEAR_ON_RESET : (r_state == CLEAR);
  assign bus.rsp_valid = r_rsp_valid && !reset;
  assign bus.rsp_err   = r_rsp_err && !reset;
  assign bus.rsp_rdata = (r_rsp_load && !reset) ? load_extend(w_ld_word, r_rsp_f3, r_rsp_lane)
                                                : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dmem_ctrl.sv
`default_nettype none
// ============================================================================
// tb_lsu_dmem_ctrl : three LSU configurations driven from one scoreboard
// Revision: 1.0
// ============================================================================
module tb_lsu_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [3];
  int          sel = 0;
  logic        d_valid = 1'b0;
  logic        d_we = 1'b0;
  logic [2:0]  d_f3 = 3'b0;
  logic [31:0] d_addr = 32'h0;
  logic [31:0] d_wdata = 32'h0;

  lsu_dmem_ctrl_if if0 ();
  lsu_dmem_ctrl_if if1 ();
  lsu_dmem_ctrl_if if2 ();

  assign if0.req_valid = d_valid && (sel == 0);
  assign if1.req_valid = d_valid && (sel == 1);
  assign if2.req_valid = d_valid && (sel == 2);
  assign if0.req_we = d_we;       assign if1.req_we = d_we;       assign if2.req_we = d_we;
  assign if0.req_funct3 = d_f3;   assign if1.req_funct3 = d_f3;   assign if2.req_funct3 = d_f3;
  assign if0.req_addr = d_addr;   assign if1.req_addr = d_addr;   assign if2.req_addr = d_addr;
  assign if0.req_wdata = d_wdata; assign if1.req_wdata = d_wdata; assign if2.req_wdata = d_wdata;

  lsu_dmem_ctrl #(.DEPTH_WORDS(64), .RD_LATENCY(1), .CLEAR_ON_RESET(1'b1))
    u_dut0 (.clk(clk), .reset(rst[0]), .bus(if0));
  lsu_dmem_ctrl #(.DEPTH_WORDS(64), .RD_LATENCY(3), .CLEAR_ON_RESET(1'b1))
    u_dut1 (.clk(clk), .reset(rst[1]), .bus(if1));
  lsu_dmem_ctrl #(.DEPTH_WORDS(64), .RD_LATENCY(2), .CLEAR_ON_RESET(1'b0))
    u_dut2 (.clk(clk), .reset(rst[2]), .bus(if2));

  logic        rdy [3], rv [3], re [3], bz [3];
  logic [31:0] rd  [3];
  assign rdy[0] = if0.req_ready; assign rdy[1] = if1.req_ready; assign rdy[2] = if2.req_ready;
  assign rv[0]  = if0.rsp_valid; assign rv[1]  = if1.rsp_valid; assign rv[2]  = if2.rsp_valid;
  assign re[0]  = if0.rsp_err;   assign re[1]  = if1.rsp_err;   assign re[2]  = if2.rsp_err;
  assign bz[0]  = if0.busy;      assign bz[1]  = if1.busy;      assign bz[2]  = if2.busy;
  assign rd[0]  = if0.rsp_rdata; assign rd[1]  = if1.rsp_rdata; assign rd[2]  = if2.rsp_rdata;

  int lat_tab [3] = '{1, 3, 2};

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  exp_t sb [$];
  vec_t vecs [$];
  int   errors = 0;
  int   checks = 0;
  int   ncyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, ncyc);
    end
  endtask

  // Response monitor: every rsp_valid must match the head of the scoreboard
  always @(negedge clk) begin
    exp_t e;
    ncyc++;
    for (int i = 0; i < 3; i++) begin
      if (rv[i]) begin
        if (i != sel || sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got rsp_valid=1 expected none (cycle %0d)", i, ncyc);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", rd[i], e.rdata);
          chk("rsp_err", {31'h0, re[i]}, {31'h0, e.err});
          chk("rsp_cycle", ncyc, e.due);
        end
      end
    end
    if (sb.size() > 0 && sb[0].due < ncyc) begin
      checks++;
      errors++;
      $display("FAIL missing_rsp dut%0d: got no rsp_valid expected one at cycle %0d", sel, sb[0].due);
      void'(sb.pop_front());
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input bit push, output int acc, output int waited);
    d_valid = 1'b1; d_we = we; d_f3 = f3; d_addr = addr; d_wdata = wdata;
    waited = 0;
    acc = -1;
    while (!rdy[sel] && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    if (!rdy[sel]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d: got req_ready=0 expected 1 within 300 cycles", sel);
      d_valid = 1'b0;
      return;
    end
    @(posedge clk);
    acc = ncyc;
    if (push) sb.push_back('{exp_rd, exp_err, acc + ((we || exp_err) ? 1 : lat_tab[sel])});
    @(negedge clk);
    d_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain dut%0d: got %0d pending responses expected 0", sel, sb.size());
      sb.delete();
    end
  endtask

  task automatic addv(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata, input logic err);
    vecs.push_back('{we, f3, addr, wdata, rdata, err});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected finish before 100000 ns");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc1, acc2, w1, w2, c0, c1, bad;

    addv(0, 3'b010, 32'h3C, 32'h0,         32'h00000000, 0);
    addv(1, 3'b010, 32'h10, 32'h8081F0F7,  32'h00000000, 0);
    addv(0, 3'b000, 32'h10, 32'h0,         32'hFFFFFFF7, 0);
    addv(0, 3'b100, 32'h10, 32'h0,         32'h000000F7, 0);
    addv(0, 3'b001, 32'h10, 32'h0,         32'hFFFFF0F7, 0);
    addv(0, 3'b101, 32'h10, 32'h0,         32'h0000F0F7, 0);
    addv(0, 3'b000, 32'h13, 32'h0,         32'hFFFFFF80, 0);
    addv(0, 3'b100, 32'h12, 32'h0,         32'h00000081, 0);
    addv(0, 3'b001, 32'h12, 32'h0,         32'hFFFF8081, 0);
    addv(0, 3'b010, 32'h10, 32'h0,         32'h8081F0F7, 0);
    addv(1, 3'b010, 32'h20, 32'h11223344,  32'h00000000, 0);
    addv(1, 3'b000, 32'h21, 32'hFFFFFFAA,  32'h00000000, 0);
    addv(0, 3'b010, 32'h20, 32'h0,         32'h1122AA44, 0);
    addv(1, 3'b001, 32'h22, 32'hDEAD5566,  32'h00000000, 0);
    addv(0, 3'b010, 32'h20, 32'h0,         32'h5566AA44, 0);
    addv(0, 3'b010, 32'h02, 32'h0,         32'h00000000, 1);
    addv(0, 3'b001, 32'h05, 32'h0,         32'h00000000, 1);
    addv(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h00000000, 1);
    addv(0, 3'b011, 32'h00, 32'h0,         32'h00000000, 1);
    addv(1, 3'b100, 32'h00, 32'hDEADBEEF,  32'h00000000, 1);
    addv(0, 3'b101, 32'h23, 32'h0,         32'h00000000, 1);
    addv(0, 3'b010, 32'h00, 32'h0,         32'h00000000, 0);
    addv(1, 3'b010, 32'hFC, 32'hA5A5A5A5,  32'h00000000, 0);
    addv(0, 3'b010, 32'hFC, 32'h0,         32'hA5A5A5A5, 0);

    // Reset all three units and check the reset-time outputs
    for (int i = 0; i < 3; i++) rst[i] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", {31'h0, rdy[i]}, 32'h0);
      chk("reset_rsp_valid", {31'h0, rv[i]}, 32'h0);
      chk("reset_rdata", rd[i], 32'h0);
      chk("reset_busy", {31'h0, bz[i]}, (i < 2) ? 32'h1 : 32'h0);
    end
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;
    #1;
    chk("noclear_busy", {31'h0, bz[2]}, 32'h0);
    chk("noclear_ready", {31'h0, rdy[2]}, 32'h1);
    c0 = 0; c1 = 0; bad = 0;
    for (int n = 0; n < 200; n++) begin
      if (bz[0]) c0++;
      if (bz[1]) c1++;
      if ((bz[0] && rdy[0]) || (bz[1] && rdy[1])) bad++;
      if (!bz[0] && !bz[1]) break;
      @(negedge clk);
      #1;
    end
    chk("clear_cycles_dut0", c0, 64);
    chk("clear_cycles_dut1", c1, 64);
    chk("ready_during_clear", bad, 0);

    // Same vector table against latency 1 and latency 3
    for (int s = 0; s < 2; s++) begin
      sel = s;
      foreach (vecs[k])
        issue(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wdata,
              vecs[k].rdata, vecs[k].err, 1'b1, acc1, w1);
      drain();
    end

    // Latency 3: back-to-back loads, ready low while waiting
    sel = 1;
    issue(0, 3'b010, 32'h20, 32'h0, 32'h5566AA44, 0, 1'b1, acc1, w1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'h8081F0F7, 0, 1'b1, acc2, w2);
    chk("b2b_accept_gap", acc2 - acc1, 3);
    chk("b2b_ready_low_cycles", w2, 2);
    drain();

    // Latency 2, no clear: reset during RD_WAIT drops the load, keeps memory
    sel = 2;
    issue(1, 3'b010, 32'h08, 32'hCAFEBABE, 32'h0, 0, 1'b1, acc1, w1);
    issue(0, 3'b010, 32'h08, 32'h0, 32'h0, 0, 1'b0, acc1, w1);
    rst[2] = 1'b1;
    repeat (2) @(negedge clk);
    chk("midload_reset_ready", {31'h0, rdy[2]}, 32'h0);
    chk("midload_reset_rdata", rd[2], 32'h0);
    rst[2] = 1'b0;
    #1;
    chk("midload_release_ready", {31'h0, rdy[2]}, 32'h1);
    chk("midload_release_busy", {31'h0, bz[2]}, 32'h0);
    issue(0, 3'b010, 32'h08, 32'h0, 32'hCAFEBABE, 0, 1'b1, acc1, w1);
    issue(0, 3'b100, 32'h0B, 32'h0, 32'h000000CA, 0, 1'b1, acc1, w1);
    drain();

    // Clear wipes memory, and a reset mid-clear restarts the full sweep
    sel = 0;
    issue(1, 3'b010, 32'h3C, 32'h12345678, 32'h0, 0, 1'b1, acc1, w1);
    issue(0, 3'b010, 32'h3C, 32'h0, 32'h12345678, 0, 1'b1, acc1, w1);
    drain();
    rst[0] = 1'b1;
    repeat (2) @(negedge clk);
    rst[0] = 1'b0;
    repeat (10) @(negedge clk);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    #1;
    c0 = 0;
    for (int n = 0; n < 200; n++) begin
      if (!bz[0]) break;
      c0++;
      @(negedge clk);
      #1;
    end
    chk("reclear_cycles", c0, 64);
    issue(0, 3'b010, 32'h3C, 32'h0, 32'h00000000, 0, 1'b1, acc1, w1);
    issue(0, 3'b010, 32'h10, 32'h0, 32'h00000000, 0, 1'b1, acc1, w1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
